// File: rtl/binary_pixel_packer_if.sv
// Pixel-stream / packed-word bundle between RAW2RGB, the packer and the SDRAM WR1 port.
interface binary_pixel_packer_if #(parameter int WORD_W = 16);
  logic              iEN, iFVAL, iDVAL, iDATA;
  logic [WORD_W-1:0] oDATA;
  logic              oWR;
  logic [15:0]       oWORD_CNT, oFRAME_CNT;
  logic              oBUSY, oFRAME_DONE, oSHORT_FRAME;

  modport master (output iEN, iFVAL, iDVAL, iDATA,
                  input  oDATA, oWR, oWORD_CNT, oFRAME_CNT, oBUSY, oFRAME_DONE, oSHORT_FRAME);
  modport slave  (input  iEN, iFVAL, iDVAL, iDATA,
                  output oDATA, oWR, oWORD_CNT, oFRAME_CNT, oBUSY, oFRAME_DONE, oSHORT_FRAME);
endinterface

// File: rtl/binary_pixel_packer.sv
// Packs the thresholded 1-bit pixel stream into WORD_W-bit words for the SDRAM write FIFO,
// capturing whole frames only (frame-atomic, gated by iEN at start of frame).
module binary_pixel_packer #(
  parameter int WORD_W  = 16,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  binary_pixel_packer_if.slave px
);
  localparam int BW = $clog2(WORD_W);
  localparam int CW = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
  localparam int LW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic              fval_d;
  logic [WORD_W-1:0] sr_q, sr_nxt, data_q;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     col_cnt;
  logic [LW-1:0]     line_cnt;
  logic [15:0]       word_cnt, frame_cnt;
  logic              wr_q, done_q, short_q;
  logic              sof, eof, accept, word_full, last_px, start;
  logic [BW:0]       pad;

  assign sof    = px.iFVAL & ~fval_d;
  assign eof    = ~px.iFVAL & fval_d;
  assign sr_nxt = {px.iDATA, sr_q[WORD_W-1:1]};
  // Partial word sits in the top bit_cnt bits; shifting down right-aligns it with zero fill.
  assign pad    = (BW+1)'(WORD_W) - {1'b0, bit_cnt};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    word_full = 1'b0;
    last_px   = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      IDLE:   if (!px.iFVAL) state_d = ARMED;
      ARMED:  if (sof && px.iEN) begin
                state_d = ACTIVE;
                start   = 1'b1;
              end
      ACTIVE: begin
        accept    = px.iDVAL;
        word_full = px.iDVAL && (bit_cnt == BW'(WORD_W-1));
        last_px   = px.iDVAL && (col_cnt == CW'(LINE_W-1)) && (line_cnt == LW'(FRAME_H-1));
        // The last pixel wins over a coincident EOF: the frame is complete, not short.
        if (last_px)  state_d = DONE;
        else if (eof) state_d = FLUSH;
      end
      FLUSH:  state_d = ARMED;
      DONE:   if (!px.iFVAL) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_d    <= 1'b0;
      sr_q      <= '0;
      data_q    <= '0;
      bit_cnt   <= '0;
      col_cnt   <= '0;
      line_cnt  <= '0;
      word_cnt  <= '0;
      frame_cnt <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      fval_d <= px.iFVAL;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (start) begin
        sr_q     <= '0;
        bit_cnt  <= '0;
        col_cnt  <= '0;
        line_cnt <= '0;
        word_cnt <= '0;
        short_q  <= 1'b0;
      end
      if (accept) begin
        sr_q    <= sr_nxt;
        bit_cnt <= word_full ? '0 : bit_cnt + 1'b1;
        if (col_cnt == CW'(LINE_W-1)) begin
          col_cnt  <= '0;
          line_cnt <= line_cnt + 1'b1;
        end else begin
          col_cnt  <= col_cnt + 1'b1;
        end
      end
      if (word_full) begin
        data_q   <= sr_nxt;
        wr_q     <= 1'b1;
        word_cnt <= sat_inc(word_cnt);
      end
      if (last_px) begin
        done_q    <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (state_q == ACTIVE && eof && !last_px) short_q <= 1'b1;
      if (state_q == FLUSH) begin
        if (bit_cnt != '0) begin
          data_q   <= sr_q >> pad;
          wr_q     <= 1'b1;
          word_cnt <= sat_inc(word_cnt);
        end
        bit_cnt   <= '0;
        done_q    <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign px.oDATA        = data_q;
  assign px.oWR          = wr_q;
  assign px.oWORD_CNT    = word_cnt;
  assign px.oFRAME_CNT   = frame_cnt;
  assign px.oBUSY        = (state_q == ACTIVE) || (state_q == FLUSH);
  assign px.oFRAME_DONE  = done_q;
  assign px.oSHORT_FRAME = short_q;
endmodule

// File: tb/tb_binary_pixel_packer.sv
// Bench for binary_pixel_packer on a reduced 32x4 frame: table of frame scenarios, random
// frames, and a mid-frame reset, all checked against a chunk-and-pack reference model.
module tb_binary_pixel_packer;
  localparam int W = 16, LINE = 32, FH = 4, FP = LINE * FH;
  localparam int PAT_ALT = 0, PAT_ONE = 1, PAT_HALF = 2, PAT_RND = 3;

  typedef struct {
    int npix; int gap; int pat; bit en; int en_drop; bit eof_px;
    int exp_words; bit exp_short;
  } frame_t;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  binary_pixel_packer_if #(.WORD_W(W)) px();
  binary_pixel_packer #(.WORD_W(W), .LINE_W(LINE), .FRAME_H(FH)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .px(px));

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int exp_frames = 0, exp_wc = 0;
  bit exp_short = 0;

  logic [W-1:0] wq_data[$];
  int           wq_cyc[$];
  int           done_n, busy_n;
  bit           done_wr;

  always @(negedge iCLK) begin
    if (px.oWR) begin
      wq_data.push_back(px.oDATA);
      wq_cyc.push_back(cyc);
    end
    if (px.oFRAME_DONE) begin
      done_n++;
      done_wr = px.oWR;
    end
    if (px.oBUSY) busy_n++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit f, input bit d, input bit b);
    px.iFVAL = f; px.iDVAL = d; px.iDATA = b;
    @(posedge iCLK); #1;
  endtask

  task automatic clear_mon();
    wq_data.delete(); wq_cyc.delete();
    done_n = 0; busy_n = 0; done_wr = 0;
  endtask

  // Sends one frame and checks it: words are the pixel list cut into W-bit chunks,
  // first pixel in bit 0, a trailing partial chunk zero-filled at the top.
  task automatic send_frame(input frame_t f);
    bit           pix[$];
    int           acc[$];
    bit           b;
    logic [W-1:0] e;
    px.iEN = f.en;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    clear_mon();
    drive(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < f.npix; p++) begin
      repeat (f.gap) drive(1'b1, 1'b0, 1'b0);
      case (f.pat)
        PAT_ALT:  b = (p % 2 == 0);
        PAT_ONE:  b = 1'b1;
        PAT_HALF: b = ((p / W) % 2 == 0);
        default:  b = 1'($urandom_range(0, 1));
      endcase
      if (p == f.en_drop) px.iEN = 1'b0;
      drive(!(f.eof_px && p == f.npix - 1), 1'b1, b);
      pix.push_back(b);
      acc.push_back(cyc);
    end
    if (f.npix == FP && !f.eof_px) repeat (3) drive(1'b1, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    if (f.en) begin
      exp_frames++;
      exp_wc    = f.exp_words;
      exp_short = f.exp_short;
    end
    check("word_pulses", wq_data.size(), f.exp_words);
    for (int w = 0; w < f.exp_words && w < wq_data.size(); w++) begin
      e = '0;
      for (int i = 0; i < W; i++) if (w * W + i < f.npix) e[i] = pix[w * W + i];
      check("oDATA", wq_data[w], e);
      if ((w + 1) * W <= f.npix) check("oWR_latency", wq_cyc[w], acc[(w + 1) * W - 1]);
    end
    check("frame_done_pulses", done_n, f.en ? 1 : 0);
    if (f.en && f.npix == FP) check("done_with_last_wr", done_wr, 1);
    check("busy_seen", busy_n > 0, f.en);
    check("oFRAME_CNT", px.oFRAME_CNT, exp_frames);
    check("oWORD_CNT", px.oWORD_CNT, exp_wc);
    check("oSHORT_FRAME", px.oSHORT_FRAME, exp_short);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t tbl[9];
    frame_t r;
    tbl[0] = '{FP, 0, PAT_ALT,  1'b1, -1, 1'b0, 8, 1'b0};  // full frame 1010..
    tbl[1] = '{FP, 0, PAT_ONE,  1'b0, -1, 1'b0, 0, 1'b0};  // disabled at SOF
    tbl[2] = '{20, 0, PAT_ONE,  1'b1, -1, 1'b0, 2, 1'b1};  // FFFF then 000F
    tbl[3] = '{FP, 0, PAT_ALT,  1'b1, 64, 1'b0, 8, 1'b0};  // iEN drops mid-frame
    tbl[4] = '{FP, 0, PAT_ONE,  1'b0, -1, 1'b0, 0, 1'b0};  // following frame skipped
    tbl[5] = '{FP, 2, PAT_HALF, 1'b1, -1, 1'b0, 8, 1'b0};  // DVAL every 3rd cycle
    tbl[6] = '{32, 1, PAT_RND,  1'b1, -1, 1'b1, 2, 1'b1};  // EOF pixel completes a word
    tbl[7] = '{0,  0, PAT_ONE,  1'b1, -1, 1'b0, 0, 1'b1};  // empty frame
    tbl[8] = '{45, 3, PAT_RND,  1'b1, -1, 1'b1, 3, 1'b1};  // partial flush after EOF pixel

    px.iEN = 1'b0; px.iFVAL = 1'b0; px.iDVAL = 1'b0; px.iDATA = 1'b0;
    clear_mon();
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_oDATA", px.oDATA, 0);
    check("rst_flags", {px.oWR, px.oBUSY, px.oFRAME_DONE, px.oSHORT_FRAME}, 0);
    check("rst_counts", {px.oWORD_CNT, px.oFRAME_CNT}, 0);
    iRST_N = 1'b1;

    for (int i = 0; i < 9; i++) send_frame(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      r.npix    = (i == 0) ? FP : int'($urandom_range(0, FP));
      r.gap     = int'($urandom_range(0, 3));
      r.pat     = PAT_RND;
      r.en      = ($urandom_range(0, 3) != 0);
      r.en_drop = -1;
      r.eof_px  = 1'($urandom_range(0, 1));
      r.exp_words = r.en ? (r.npix + W - 1) / W : 0;
      r.exp_short = (r.npix < FP);
      send_frame(r);
    end

    // Reset in the middle of a captured frame, then a clean frame.
    px.iEN = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 50; p++) drive(1'b1, 1'b1, p[0]);
    iRST_N = 1'b0;
    #1;
    check("midrst_flags", {px.oWR, px.oBUSY, px.oFRAME_DONE, px.oSHORT_FRAME}, 0);
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    check("midrst_counts", {px.oWORD_CNT, px.oFRAME_CNT}, 0);
    check("midrst_oDATA", px.oDATA, 0);
    iRST_N = 1'b1;
    clear_mon();
    for (int p = 53; p < FP; p++) drive(1'b1, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("postrst_words", wq_data.size(), 0);
    check("postrst_done", done_n, 0);
    exp_frames = 0; exp_wc = 0; exp_short = 0;
    send_frame(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
